ctrl_decode_pipe: RTL and testbench

- Registered, parametrised successor to the combinational main control decoder.
- Decodes the ID-stage opcode and registers the control bundle into the ID/EX boundary.
- Inserts bubbles on stall and flush.
- Runs a halt-drain state machine that freezes fetch and reports when the pipeline is empty.
- Optionally decodes extended immediate ALU ops, and flags and counts illegal opcodes.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_decode_comb.sv | 46 ++++
 rtl/ctrl_decode_pipe.sv | 88 ++++++++
 tb/tb_ctrl_decode_pipe.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU classes and the registered control bundle shared by the decode pipe.
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [2:0] ALU_MEM  = 3'd0;
  localparam logic [2:0] ALU_BR   = 3'd1;
  localparam logic [2:0] ALU_R    = 3'd2;
  localparam logic [2:0] ALU_ADDI = 3'd3;
  localparam logic [2:0] ALU_ANDI = 3'd4;
  localparam logic [2:0] ALU_ORI  = 3'd5;
  localparam logic [2:0] ALU_SLTI = 3'd6;
  typedef struct packed {
    logic       valid;
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       nbranch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_bundle_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam ctrl_bundle_t BUBBLE = '0;
  // flags order: reg_dst, jump, branch, nbranch, mem_write, mem_to_reg, alu_src, reg_write
  function automatic ctrl_bundle_t mk(input logic [7:0] flags, input logic [2:0] alu);
    return {1'b1, flags, alu};
  endfunction
endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational opcode to control bundle, with illegal and hlt detection.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter bit EXT_OPS = 1'b0
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_bundle_t   ctrl,
  output logic           illegal,
  output logic           is_hlt
);
  logic [5:0] op;
  logic       hi;
  assign op = opcode[5:0];
  assign hi = (opcode >> 6) != '0;
  always_comb begin
    ctrl = BUBBLE;
    illegal = 1'b0;
    is_hlt = 1'b0;
    if (hi) illegal = 1'b1;
    else case (op)
      OP_RTYPE: ctrl = mk(8'b1000_0001, ALU_R);
      OP_LW:    ctrl = mk(8'b0000_0111, ALU_MEM);
      OP_SW:    ctrl = mk(8'b0000_1010, ALU_MEM);
      OP_BEQ:   ctrl = mk(8'b0010_0000, ALU_BR);
      OP_BNE:   ctrl = mk(8'b0001_0000, ALU_BR);
      OP_ADDI:  ctrl = mk(8'b0000_0011, ALU_ADDI);
      OP_J:     ctrl = mk(8'b0100_0000, ALU_MEM);
      OP_HLT:   is_hlt = 1'b1;
      OP_ANDI: begin
        ctrl = EXT_OPS ? mk(8'b0000_0011, ALU_ANDI) : BUBBLE;
        illegal = !EXT_OPS;
      end
      OP_ORI: begin
        ctrl = EXT_OPS ? mk(8'b0000_0011, ALU_ORI) : BUBBLE;
        illegal = !EXT_OPS;
      end
      OP_SLTI: begin
        ctrl = EXT_OPS ? mk(8'b0000_0011, ALU_SLTI) : BUBBLE;
        illegal = !EXT_OPS;
      end
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered ID/EX control decode with bubble insertion, halt drain and illegal-op tracking.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int ALUOPW       = 2,
  parameter bit EXT_OPS      = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNTW         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPW-1:0]    id_opcode,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_nbranch,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [ALUOPW-1:0] ex_alu_op,
  output logic              fetch_freeze,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNTW-1:0]   illegal_cnt
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  if (ALUOPW < 2 || (EXT_OPS && ALUOPW < 3) || DRAIN_CYCLES < 1) begin : g_bad_params
    $error("ctrl_decode_pipe: invalid parameter combination");
  end
  state_t       state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  ctrl_bundle_t dec, ex;
  logic         illegal, is_hlt, accept;
  ctrl_decode_comb #(.OPW(OPW), .EXT_OPS(EXT_OPS)) u_dec (
    .opcode (id_opcode),
    .ctrl   (dec),
    .illegal(illegal),
    .is_hlt (is_hlt)
  );
  assign accept = id_valid & ~stall & ~flush & (state == RUN);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (accept && is_hlt) begin
      state_nx = DRAIN;
      cnt_nx = DW'(DRAIN_CYCLES - 1);
    end else if (state == DRAIN) begin
      state_nx = cnt == '0 ? HALTED : DRAIN;
      cnt_nx = cnt == '0 ? cnt : cnt - DW'(1);
    end
  end
  // hlt and illegal opcodes already decode to BUBBLE, so only accept gates the load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      ex <= BUBBLE;
      illegal_op <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ex <= accept ? dec : BUBBLE;
      if (accept && illegal) begin
        illegal_op <= 1'b1;
        illegal_cnt <= &illegal_cnt ? illegal_cnt : illegal_cnt + CNTW'(1);
      end
    end
  end
  assign ex_valid      = ex.valid;
  assign ex_reg_dst    = ex.reg_dst;
  assign ex_jump       = ex.jump;
  assign ex_branch     = ex.branch;
  assign ex_nbranch    = ex.nbranch;
  assign ex_mem_write  = ex.mem_write;
  assign ex_mem_to_reg = ex.mem_to_reg;
  assign ex_alu_src    = ex.alu_src;
  assign ex_reg_write  = ex.reg_write;
  assign ex_alu_op     = ALUOPW'(ex.alu_op);
  assign fetch_freeze  = state != RUN;
  assign halted        = state == HALTED;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: scoreboard bench driving a base and an extended-op configuration from one stimulus stream.
module tb_ctrl_decode_pipe;
  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic [2:0] a;
    logic       fz;
    logic       h;
    logic       il;
    logic [7:0] n;
  } obs_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [7:0] id_opcode = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  wire        v0, fz0, h0, il0, v1, fz1, h1, il1;
  wire [7:0]  c0, c1, n0;
  wire [1:0]  a0, n1;
  wire [2:0]  a1;
  obs_t       o0, o1;
  obs_t       q0[$], q1[$];
  int         tests = 0, fails = 0;
  int         age[2], ill_n[2];
  int         drain[2] = '{3, 1};
  int         cmax[2] = '{255, 3};
  logic [7:0] tbl[13] = '{8'h00, 8'h23, 8'h2B, 8'h04, 8'h05, 8'h08, 8'h02,
                          8'h0C, 8'h0D, 8'h0A, 8'h3F, 8'h01, 8'h3E};
  always #5 clk = ~clk;
  ctrl_decode_pipe u_d0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode[5:0]),
    .stall(stall), .flush(flush), .ex_valid(v0), .ex_reg_dst(c0[7]), .ex_jump(c0[6]),
    .ex_branch(c0[5]), .ex_nbranch(c0[4]), .ex_mem_write(c0[3]), .ex_mem_to_reg(c0[2]),
    .ex_alu_src(c0[1]), .ex_reg_write(c0[0]), .ex_alu_op(a0), .fetch_freeze(fz0),
    .halted(h0), .illegal_op(il0), .illegal_cnt(n0)
  );
  ctrl_decode_pipe #(.OPW(8), .ALUOPW(3), .EXT_OPS(1'b1), .DRAIN_CYCLES(1), .CNTW(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .stall(stall), .flush(flush), .ex_valid(v1), .ex_reg_dst(c1[7]), .ex_jump(c1[6]),
    .ex_branch(c1[5]), .ex_nbranch(c1[4]), .ex_mem_write(c1[3]), .ex_mem_to_reg(c1[2]),
    .ex_alu_src(c1[1]), .ex_reg_write(c1[0]), .ex_alu_op(a1), .fetch_freeze(fz1),
    .halted(h1), .illegal_op(il1), .illegal_cnt(n1)
  );
  assign o0 = {v0, c0, {1'b0, a0}, fz0, h0, il0, n0};
  assign o1 = {v1, c1, a1, fz1, h1, il1, {6'b0, n1}};
  // {legal_non_hlt, illegal, flags[7:0], alu[2:0]}; flags: dst,jmp,beq,bne,memw,m2r,src,wr
  function automatic logic [12:0] ref_dec(input logic [7:0] op, input bit ext);
    case (op)
      8'h00: return {2'b10, 8'b1000_0001, 3'd2};
      8'h23: return {2'b10, 8'b0000_0111, 3'd0};
      8'h2B: return {2'b10, 8'b0000_1010, 3'd0};
      8'h04: return {2'b10, 8'b0010_0000, 3'd1};
      8'h05: return {2'b10, 8'b0001_0000, 3'd1};
      8'h08: return {2'b10, 8'b0000_0011, 3'd3};
      8'h02: return {2'b10, 8'b0100_0000, 3'd0};
      8'h0C: return ext ? {2'b10, 8'b0000_0011, 3'd4} : 13'h0800;
      8'h0D: return ext ? {2'b10, 8'b0000_0011, 3'd5} : 13'h0800;
      8'h0A: return ext ? {2'b10, 8'b0000_0011, 3'd6} : 13'h0800;
      8'h3F: return 13'h0000;
      default: return 13'h0800;
    endcase
  endfunction
  task automatic chk(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (v|flags|alu|frz|hlt|ill|cnt) t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] op, input logic s, input logic f);
    @(negedge clk);
    id_valid = v;
    id_opcode = op;
    stall = s;
    flush = f;
    for (int k = 0; k < 2; k++) begin
      logic [7:0]  o;
      logic [12:0] r;
      bit          acc;
      obs_t        e;
      o = k == 1 ? op : {2'b00, op[5:0]};
      r = ref_dec(o, k == 1);
      acc = v && !s && !f && age[k] == 0;
      e = '0;
      if (acc && r[12]) begin
        e.v = 1'b1;
        e.c = r[10:3];
        e.a = r[2:0];
      end
      if (acc && r[11]) ill_n[k]++;
      if (acc && o == 8'h3F) age[k] = 1;
      else if (age[k] > 0) age[k]++;
      e.fz = age[k] >= 1;
      e.h = age[k] >= drain[k] + 1;
      e.il = ill_n[k] > 0;
      e.n = 8'(ill_n[k] > cmax[k] ? cmax[k] : ill_n[k]);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask
  task automatic rnd_step(input bit heavy_flush);
    logic [7:0] op;
    op = tbl[$urandom_range(0, 12)];
    if (op == 8'h3F && $urandom_range(0, 3) != 0) op = 8'h08;
    if ($urandom_range(0, 6) == 0) op = 8'($urandom_range(0, 255));
    step($urandom_range(0, 7) != 0, op, $urandom_range(0, 4) == 0,
         heavy_flush ? $urandom_range(0, 1) == 1 : $urandom_range(0, 6) == 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_d0", o0, '0);
    chk("async_reset_d1", o1, '0);
    age = '{0, 0};
    ill_n = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) chk("pipe_d0", o0, q0.pop_front());
      if (q1.size() != 0) chk("pipe_d1", o1, q1.pop_front());
    end
  end
  initial begin
    age = '{0, 0};
    ill_n = '{0, 0};
    #1 rst_n = 1'b0;
    #1;
    chk("reset_d0", o0, '0);
    chk("reset_d1", o1, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h23, 0, 0);
    step(1, 8'h2B, 0, 0);
    step(1, 8'h04, 0, 0);
    step(1, 8'h05, 0, 0);
    step(1, 8'h08, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 1, 0);
    step(1, 8'h00, 1, 0);
    step(1, 8'h00, 0, 0);
    step(1, 8'h3F, 0, 1);
    step(1, 8'h08, 0, 0);
    step(1, 8'h0D, 0, 0);
    repeat (5) step(1, 8'h01, 0, 0);
    step(1, 8'h01, 1, 0);
    step(1, 8'h01, 0, 1);
    step(1, 8'h4D, 0, 0);
    step(0, 8'h23, 0, 0);
    step(1, 8'h3F, 1, 0);
    step(1, 8'h3F, 0, 0);
    repeat (20) rnd_step(1'b1);
    do_reset();
    repeat (4) begin
      repeat (60) rnd_step(1'b0);
      do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
